mem_access_bridge: RTL and testbench

//  Sits between the multicycle CPU datapath memory port and the word-wide synchronous RAM.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/mem_access_bridge_lane_unit.sv | 47 ++++
 rtl/mem_access_bridge.sv | 97 +++++++++
 tb/tb_mem_access_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared memory-port types: access size encoding (matches the datapath MemDataSize select)
// and the bridge FSM state encoding.
package mips_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    MERGE_WR,
    WR,
    RESP,
    ERR
  } bridge_state_t;

  typedef struct packed {
    logic        wr;
    mem_size_t   size;
    logic [31:0] wdata;
  } req_t;

  // Reserved size is reported as misaligned so it never reaches the RAM.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
    case (size)
      SZ_WORD: return lane != 2'b00;
      SZ_HALF: return lane[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_bridge_lane_unit.sv
// Combinational lane steering: zero-extended load extraction and sub-word store merge
// against the old RAM word, little-endian byte lanes.
module lane_unit
  import mips_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr,
  input  mem_size_t   size,
  output logic [31:0] merged_word,
  output logic [31:0] extracted_zero_ext
);

  logic [NUM_LANES-1:0]      lane_en;
  logic [NUM_LANES-1:0][7:0] old_lanes, new_lanes, merged_lanes;
  logic [31:0]               shifted;

  assign old_lanes = word_in;
  assign shifted   = word_in >> {addr, 3'b000};

  // Store data is replicated so every enabled lane sees the right-justified value.
  always_comb begin
    lane_en            = '1;
    new_lanes          = wdata;
    extracted_zero_ext = shifted;
    case (size)
      SZ_BYTE: begin
        lane_en            = NUM_LANES'(1) << addr;
        new_lanes          = {4{wdata[7:0]}};
        extracted_zero_ext = {24'h0, shifted[7:0]};
      end
      SZ_HALF: begin
        lane_en            = addr[1] ? 4'b1100 : 4'b0011;
        new_lanes          = {2{wdata[15:0]}};
        extracted_zero_ext = {16'h0, shifted[15:0]};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged_lanes[i] = lane_en[i] ? new_lanes[i] : old_lanes[i];
  end

  assign merged_word = merged_lanes;

endmodule

// File: rtl/mem_access_bridge.sv
// CPU memory port to word-wide synchronous RAM: one access at a time, sub-word loads,
// read-modify-write sub-word stores, misalignment errors.
module mem_access_bridge
  import mips_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  bridge_state_t     state, state_nxt;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       old_q, rdata_q, lane_word, merged, extracted;
  logic              accept, lat_done;

  assign accept   = req_valid && req_ready;
  assign lat_done = (cnt_q == CNT_W'(MEM_LATENCY));

  // Extraction reads the live RAM word; merging uses the latched old word.
  assign lane_word = (state == RD_WAIT) ? mem_rdata : old_q;

  lane_unit u_lane (
    .word_in            (lane_word),
    .wdata              (req_q.wdata),
    .addr               (addr_q[1:0]),
    .size               (req_q.size),
    .merged_word        (merged),
    .extracted_zero_ext (extracted)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) begin
        if (is_misaligned(mem_size_t'(req_size), req_addr[1:0])) state_nxt = ERR;
        else if (req_wr && mem_size_t'(req_size) == SZ_WORD)     state_nxt = WR;
        else                                                     state_nxt = RD_WAIT;
      end
      RD_WAIT:      if (lat_done) state_nxt = req_q.wr ? MERGE_WR : RESP;
      MERGE_WR, WR: state_nxt = RESP;
      RESP, ERR:    state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q  <= '{wr: req_wr, size: mem_size_t'(req_size), wdata: req_wdata};
        addr_q <= req_addr;
        cnt_q  <= '0;
      end else if (state == RD_WAIT && !lat_done) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state == RD_WAIT && lat_done) begin
        if (req_q.wr) old_q   <= mem_rdata;
        else          rdata_q <= extracted;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP) || (state == ERR);
  assign resp_err   = (state == ERR);
  assign resp_rdata = (state == ERR) ? 32'h0 : rdata_q;
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wr     = (state == WR) || (state == MERGE_WR);
  assign mem_wdata  = (state == MERGE_WR) ? merged : req_q.wdata;

endmodule

// File: tb/tb_mem_access_bridge.sv
// Directed bench: two bridges (MEM_LATENCY 1 and 3) sharing the request inputs, each on its
// own RAM model with a read pipeline of matching depth.
module tb_mem_access_bridge;
  import mips_pkg::*;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  always #5 Clk = ~Clk;

  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;

  logic [1:0]       req_ready, resp_valid, resp_err, mem_wr;
  logic [1:0][31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_access_bridge #(.MEM_LATENCY(1), .ADDR_W(32)) u_dut1 (
    .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_access_bridge #(.MEM_LATENCY(3), .ADDR_W(32)) u_dut3 (
    .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // RAM models with backdoor preload port
  logic [31:0]      ram1 [16];
  logic [31:0]      ram3 [16];
  logic [31:0]      p1;
  logic [2:0][31:0] p3;
  logic             bd_we = 1'b0;
  logic [3:0]       bd_idx = '0;
  logic [31:0]      bd_data = '0;
  int               wr_cnt1 = 0;

  always @(posedge Clk) begin
    if (bd_we) begin
      ram1[bd_idx] <= bd_data;
      ram3[bd_idx] <= bd_data;
    end
    if (mem_wr[0]) begin
      ram1[mem_addr[0][5:2]] <= mem_wdata[0];
      wr_cnt1 <= wr_cnt1 + 1;
    end
    if (mem_wr[1]) ram3[mem_addr[1][5:2]] <= mem_wdata[1];
    p1 <= ram1[mem_addr[0][5:2]];
    p3 <= {p3[1:0], ram3[mem_addr[1][5:2]]};
  end
  assign mem_rdata[0] = p1;
  assign mem_rdata[1] = p3[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  // Waits for the latency-1 bridge to be idle, then presents one request for one edge.
  task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!req_ready[0] && n < 20) begin tick(); n++; end
    if (n == 20) chk("idle_timeout", {31'h0, req_ready[0]}, 32'h1);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'h0, req_ready[0]}, 32'h1);
    chk({tag, "_rvalid"}, {31'h0, resp_valid[0]}, 32'h0);
    chk({tag, "_rerr"}, {31'h0, resp_err[0]}, 32'h0);
    chk({tag, "_memwr"}, {31'h0, mem_wr[0]}, 32'h0);
    chk({tag, "_rdata"}, resp_rdata[0], 32'h0);
    chk({tag, "_maddr"}, mem_addr[0], 32'h0);
    chk({tag, "_mwdata"}, mem_wdata[0], 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_ready, exp_resp;
    int          ret_wr;
    int          acc;

    poke(4'd8, 32'h1122_3344);
    chk_reset_vals("rst");
    reset = 1'b1;
    tick();

    // word store: write in cycle 1, response in cycle 2
    send(1'b1, SZ_WORD, 32'h10, 32'hDEAD_BEEF);
    chk("ws_memwr", {31'h0, mem_wr[0]}, 32'h1);
    chk("ws_maddr", mem_addr[0], 32'h10);
    chk("ws_mwdata", mem_wdata[0], 32'hDEAD_BEEF);
    chk("ws_busy", {31'h0, req_ready[0]}, 32'h0);
    chk("ws_early_resp", {31'h0, resp_valid[0]}, 32'h0);
    tick();
    chk("ws_resp", {31'h0, resp_valid[0]}, 32'h1);
    chk("ws_memwr_once", {31'h0, mem_wr[0]}, 32'h0);
    chk("ws_ram", ram1[4], 32'hDEAD_BEEF);

    // byte and half loads at 0x22
    send(1'b0, SZ_BYTE, 32'h22, 32'h0);
    tick();
    chk("lb_early_resp", {31'h0, resp_valid[0]}, 32'h0);
    tick();
    chk("lb_resp", {31'h0, resp_valid[0]}, 32'h1);
    chk("lb_data", resp_rdata[0], 32'h0000_0022);
    send(1'b0, SZ_HALF, 32'h22, 32'h0);
    tick(2);
    chk("lh_resp", {31'h0, resp_valid[0]}, 32'h1);
    chk("lh_data", resp_rdata[0], 32'h0000_1122);

    // byte store 0x21: read, merge-write, respond
    send(1'b1, SZ_BYTE, 32'h21, 32'h0000_00AB);
    chk("sb_c1_nowr", {31'h0, mem_wr[0]}, 32'h0);
    chk("sb_maddr", mem_addr[0], 32'h20);
    tick();
    chk("sb_c2_nowr", {31'h0, mem_wr[0]}, 32'h0);
    tick();
    chk("sb_memwr", {31'h0, mem_wr[0]}, 32'h1);
    chk("sb_mwdata", mem_wdata[0], 32'h1122_AB44);
    tick();
    chk("sb_resp", {31'h0, resp_valid[0]}, 32'h1);
    chk("sb_ram", ram1[8], 32'h1122_AB44);
    chk("sb_rdata_kept", resp_rdata[0], 32'h0000_1122);

    // upper half store, then word and top-byte loads
    send(1'b1, SZ_HALF, 32'h22, 32'h0000_BEEF);
    tick(3);
    chk("sh_ram", ram1[8], 32'hBEEF_AB44);
    send(1'b0, SZ_WORD, 32'h20, 32'h0);
    tick(2);
    chk("lw_data", resp_rdata[0], 32'hBEEF_AB44);
    send(1'b0, SZ_BYTE, 32'h23, 32'h0);
    tick(2);
    chk("lb3_data", resp_rdata[0], 32'h0000_00BE);

    // misaligned half store and reserved size
    ret_wr = wr_cnt1;
    send(1'b1, SZ_HALF, 32'h23, 32'h0000_5555);
    chk("mis_resp", {31'h0, resp_valid[0]}, 32'h1);
    chk("mis_err", {31'h0, resp_err[0]}, 32'h1);
    chk("mis_rdata", resp_rdata[0], 32'h0);
    chk("mis_memwr", {31'h0, mem_wr[0]}, 32'h0);
    tick();
    chk("mis_pulse", {31'h0, resp_valid[0]}, 32'h0);
    send(1'b0, SZ_RSVD, 32'h20, 32'h0);
    chk("rsvd_err", {31'h0, resp_err[0]}, 32'h1);
    tick();
    chk("mis_no_write", wr_cnt1, ret_wr);
    chk("mis_ram", ram1[8], 32'hBEEF_AB44);

    // reset asserted in RD_WAIT of a byte store
    send(1'b1, SZ_BYTE, 32'h20, 32'h0000_0077);
    #2 reset = 1'b0;
    #1 chk_reset_vals("midrst");
    tick(2);
    reset = 1'b1;
    tick();
    chk("midrst_no_write", wr_cnt1, ret_wr);
    chk("midrst_ram", ram1[8], 32'hBEEF_AB44);
    send(1'b0, SZ_BYTE, 32'h20, 32'h0);
    tick(2);
    chk("post_rst_resp", {31'h0, resp_valid[0]}, 32'h1);
    chk("post_rst_data", resp_rdata[0], 32'h0000_0044);

    // MEM_LATENCY=3 back-to-back load / word store / load with req_valid held
    tick(8);
    poke(4'd12, 32'hCAFE_F00D);
    chk("b2b_idle", {31'h0, req_ready[1]}, 32'h1);
    exp_ready = 16'b1000_0010_0100_0001;  // accepts in cycles 0, 6, 9; idle again at 15
    exp_resp  = 16'b0100_0001_0010_0000;  // responses in cycles 5, 8, 14
    acc = 0;
    req_valid = 1'b1; req_wr = 1'b0; req_size = SZ_BYTE; req_addr = 32'h31; req_wdata = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      chk($sformatf("b2b_ready_c%0d", cyc), {31'h0, req_ready[1]}, {31'h0, exp_ready[cyc]});
      chk($sformatf("b2b_resp_c%0d", cyc), {31'h0, resp_valid[1]}, {31'h0, exp_resp[cyc]});
      if (cyc == 5)  chk("b2b_lb_data", resp_rdata[1], 32'h0000_00F0);
      if (cyc == 8)  chk("b2b_sw_rdata_kept", resp_rdata[1], 32'h0000_00F0);
      if (cyc == 14) chk("b2b_lh_data", resp_rdata[1], 32'h0000_1234);
      if (req_ready[1] && req_valid) begin
        acc++;
        tick();
        case (acc)
          1: begin req_wr = 1'b1; req_size = SZ_WORD; req_addr = 32'h34; req_wdata = 32'h1234_5678; end
          2: begin req_wr = 1'b0; req_size = SZ_HALF; req_addr = 32'h36; req_wdata = '0; end
          default: req_valid = 1'b0;
        endcase
      end else begin
        tick();
      end
    end
    chk("b2b_accepts", acc, 3);
    chk("b2b_ram", ram3[13], 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
